// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trap_sequencer
// Purpose  : Trap entry/exit sequencer: fault/IRQ arbitration, cause and EPC
//            capture, pipeline drain handshake, vector and return redirects.
//            Optional macro TRAP_IRQ_RR_EN selects round-robin IRQ grant.
// Revision : 1.0 - initial release
// ============================================================================
module trap_sequencer #(
   parameter int          NUM_IRQ    = 4,
   parameter logic [15:0] VEC_BASE   = 16'h0000,
   parameter logic [15:0] VEC_STRIDE = 16'h0040
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fault_pc,
   input  logic               fault_mem,
   input  logic               fault_instr,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic [15:0]        cur_pc,
   input  logic               drain_ack,
   input  logic               eret,
   output logic               flush_req,
   output logic               redirect,
   output logic [15:0]        redirect_pc,
   output logic [15:0]        epc,
   output logic [3:0]         cause,
   output logic               in_trap,
   output logic               double_fault
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FLUSH   = 3'd1;
   localparam logic [2:0] S_VECTOR  = 3'd2;
   localparam logic [2:0] S_HANDLER = 3'd3;
   localparam logic [2:0] S_RETURN  = 3'd4;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [2:0]         r_pend;
   logic [2:0]         w_pend_nxt;
   logic [3:0]         r_cause;
   logic [15:0]        r_epc;
   logic               r_double_fault;

   logic [2:0]         w_fault;
   logic [2:0]         w_fault_src;
   logic [2:0]         w_fault_clr;
   logic [NUM_IRQ-1:0] w_irq_req;
   logic               w_irq_hit;
   logic [3:0]         w_irq_idx;
   logic               w_accept;
   logic               w_take;
   logic [3:0]         w_sel_cause;
   logic [15:0]        w_vec;

   // Returns {hit, index} of the lowest set bit.
   function automatic logic [4:0] f_lowest(input logic [NUM_IRQ-1:0] v);
      logic [4:0] res;
      res = 5'd0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (v[k]) begin
            res = {1'b1, 4'(k)};
         end
      end
      return res;
   endfunction

   assign w_fault     = {fault_instr, fault_mem, fault_pc};
   assign w_fault_src = r_pend | w_fault;
   assign w_irq_req   = irq & irq_mask;

`ifdef TRAP_IRQ_RR_EN
   logic [3:0]         r_rr_ptr;
   logic [NUM_IRQ-1:0] w_rr_ge;
   logic [4:0]         w_hi_sel;
   logic [4:0]         w_all_sel;

   // Requests at or above the pointer win; otherwise wrap to the lowest.
   always_comb begin
      w_rr_ge = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         w_rr_ge[k] = (4'(k) >= r_rr_ptr);
      end
   end

   assign w_hi_sel  = f_lowest(w_irq_req & w_rr_ge);
   assign w_all_sel = f_lowest(w_irq_req);
   assign w_irq_hit = w_all_sel[4];
   assign w_irq_idx = w_hi_sel[4] ? w_hi_sel[3:0] : w_all_sel[3:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= 4'd0;
      end else if (w_take && (w_fault_src == 3'b000)) begin
         r_rr_ptr <= (w_irq_idx == 4'(NUM_IRQ - 1)) ? 4'd0 : (w_irq_idx + 4'd1);
      end
   end
`else
   logic [4:0] w_fix_sel;

   assign w_fix_sel = f_lowest(w_irq_req);
   assign w_irq_hit = w_fix_sel[4];
   assign w_irq_idx = w_fix_sel[3:0];
`endif

   always_comb begin
      w_accept    = 1'b0;
      w_sel_cause = 4'd0;
      w_fault_clr = 3'b000;
      if (w_fault_src[0]) begin
         w_accept    = 1'b1;
         w_sel_cause = 4'd0;
         w_fault_clr = 3'b001;
      end else if (w_fault_src[1]) begin
         w_accept    = 1'b1;
         w_sel_cause = 4'd1;
         w_fault_clr = 3'b010;
      end else if (w_fault_src[2]) begin
         w_accept    = 1'b1;
         w_sel_cause = 4'd2;
         w_fault_clr = 3'b100;
      end else if (w_irq_hit) begin
         w_accept    = 1'b1;
         w_sel_cause = 4'd4 + w_irq_idx;
      end
   end

   assign w_take = (r_state == S_IDLE) && w_accept;

   // An accepted bit survives only if it was already pending and re-pulsed.
   always_comb begin
      w_pend_nxt = r_pend;
      if (r_state != S_HANDLER) begin
         if (w_take) begin
            w_pend_nxt = (w_fault_src & ~w_fault_clr) | (r_pend & w_fault & w_fault_clr);
         end else begin
            w_pend_nxt = w_fault_src;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept)  w_state_nxt = S_FLUSH;
         S_FLUSH:   if (drain_ack) w_state_nxt = S_VECTOR;
         S_VECTOR:  w_state_nxt = S_HANDLER;
         S_HANDLER: if (eret)      w_state_nxt = S_RETURN;
         S_RETURN:  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_pend         <= 3'b000;
         r_cause        <= 4'd0;
         r_epc          <= 16'h0000;
         r_double_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         if (w_take) begin
            r_cause <= w_sel_cause;
            r_epc   <= cur_pc;
         end
         if ((r_state == S_HANDLER) && (w_fault != 3'b000)) begin
            r_double_fault <= 1'b1;
         end
      end
   end

   assign w_vec = VEC_BASE + ({12'd0, r_cause} * VEC_STRIDE);

   assign flush_req    = (r_state == S_FLUSH);
   assign redirect     = (r_state == S_VECTOR) || (r_state == S_RETURN);
   assign redirect_pc  = (r_state == S_VECTOR) ? w_vec :
                         (r_state == S_RETURN) ? r_epc : 16'h0000;
   assign epc          = r_epc;
   assign cause        = r_cause;
   assign in_trap      = (r_state == S_HANDLER);
   assign double_fault = r_double_fault;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_sequencer
// Purpose  : Directed self-checking bench for trap_sequencer with a
//            transaction-level reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

   localparam int          NUM_IRQ    = 4;
   localparam logic [15:0] VEC_BASE   = 16'h0000;
   localparam logic [15:0] VEC_STRIDE = 16'h0040;

   localparam logic [2:0] P_IDLE    = 3'd0;
   localparam logic [2:0] P_FLUSH   = 3'd1;
   localparam logic [2:0] P_VECTOR  = 3'd2;
   localparam logic [2:0] P_HANDLER = 3'd3;
   localparam logic [2:0] P_RETURN  = 3'd4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic fault_pc = 1'b0, fault_mem = 1'b0, fault_instr = 1'b0;
   logic [NUM_IRQ-1:0] irq = '0, irq_mask = '0;
   logic [15:0] cur_pc = 16'h0000;
   logic drain_ack = 1'b0, eret = 1'b0;

   logic        flush_req, redirect, in_trap, double_fault;
   logic [15:0] redirect_pc, epc;
   logic [3:0]  cause;

   trap_sequencer #(
      .NUM_IRQ    (NUM_IRQ),
      .VEC_BASE   (VEC_BASE),
      .VEC_STRIDE (VEC_STRIDE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fault_pc     (fault_pc),
      .fault_mem    (fault_mem),
      .fault_instr  (fault_instr),
      .irq          (irq),
      .irq_mask     (irq_mask),
      .cur_pc       (cur_pc),
      .drain_ack    (drain_ack),
      .eret         (eret),
      .flush_req    (flush_req),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .epc          (epc),
      .cause        (cause),
      .in_trap      (in_trap),
      .double_fault (double_fault)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: trap phase, pending fault flags, captured context.
   typedef struct packed {
      logic [2:0]  phase;
      logic [2:0]  pend;
      logic [3:0]  cause;
      logic [15:0] epc;
      logic        df;
      logic [3:0]  nxt_irq;
   } ms_t;

   ms_t m;

   function automatic ms_t model_next(input ms_t s, input logic [2:0] f,
                                      input logic [NUM_IRQ-1:0] rq, input logic [15:0] pc,
                                      input logic dack, input logic er);
      ms_t n;
      int  src;
      int  cnt;
      int  i;
      n   = s;
      src = -1;
      if (s.phase == P_IDLE) begin
         for (int b = 0; b < 3; b++)
            if (src < 0 && (s.pend[b] || f[b])) src = b;
         if (src < 0) begin
            for (int k = 0; k < NUM_IRQ; k++) begin
`ifdef TRAP_IRQ_RR_EN
               i = (int'(s.nxt_irq) + k) % NUM_IRQ;
`else
               i = k;
`endif
               if (src < 0 && rq[i]) src = 4 + i;
            end
         end
         // Each fault source holds a count of outstanding events; acceptance consumes one.
         for (int b = 0; b < 3; b++) begin
            cnt = int'(s.pend[b]) + int'(f[b]);
            if (src == b) cnt = cnt - 1;
            n.pend[b] = (cnt > 0);
         end
         if (src >= 0) begin
            n.cause = 4'(src);
            n.epc   = pc;
            n.phase = P_FLUSH;
            if (src >= 4) n.nxt_irq = 4'((src - 4 + 1) % NUM_IRQ);
         end
      end else if (s.phase == P_HANDLER) begin
         if (f != 3'b000) n.df = 1'b1;
         if (er) n.phase = P_RETURN;
      end else begin
         n.pend = s.pend | f;
         if (s.phase == P_FLUSH && dack)  n.phase = P_VECTOR;
         else if (s.phase == P_VECTOR)    n.phase = P_HANDLER;
         else if (s.phase == P_RETURN)    n.phase = P_IDLE;
      end
      return n;
   endfunction

   function automatic logic [15:0] exp_rpc(input ms_t s);
      int v;
      v = int'(VEC_BASE) + int'(s.cause) * int'(VEC_STRIDE);
      if (s.phase == P_VECTOR) return 16'(v);
      if (s.phase == P_RETURN) return s.epc;
      return 16'h0000;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) m <= '0;
      else      m <= model_next(m, {fault_instr, fault_mem, fault_pc}, irq & irq_mask,
                                cur_pc, drain_ack, eret);
   end

   always @(posedge clk) begin
      #1;
      chk("m_flush_req",    {15'd0, flush_req},    {15'd0, m.phase == P_FLUSH});
      chk("m_redirect",     {15'd0, redirect},     {15'd0, (m.phase == P_VECTOR) || (m.phase == P_RETURN)});
      chk("m_redirect_pc",  redirect_pc,           exp_rpc(m));
      chk("m_epc",          epc,                   m.epc);
      chk("m_cause",        {12'd0, cause},        {12'd0, m.cause});
      chk("m_in_trap",      {15'd0, in_trap},      {15'd0, m.phase == P_HANDLER});
      chk("m_double_fault", {15'd0, double_fault}, {15'd0, m.df});
   end

   task automatic wait_flush();
      int t;
      t = 0;
      while (flush_req !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("wait_flush", {15'd0, flush_req}, 16'd1);
   endtask

   // Full trap from FLUSH through RETURN; ends at the negedge of the IDLE cycle.
   task automatic service(input logic [3:0] ec, input logic [15:0] ev, input logic [15:0] ee);
      wait_flush();
      chk("acc_cause", {12'd0, cause}, {12'd0, ec});
      chk("acc_epc", epc, ee);
      drain_ack = 1'b1;
      @(negedge clk);
      drain_ack = 1'b0;
      chk("vec_redirect", {15'd0, redirect}, 16'd1);
      chk("vec_pc", redirect_pc, ev);
      @(negedge clk);
      chk("handler_in_trap", {15'd0, in_trap}, 16'd1);
      eret = 1'b1;
      @(negedge clk);
      eret = 1'b0;
      chk("ret_redirect", {15'd0, redirect}, 16'd1);
      chk("ret_pc", redirect_pc, ee);
      @(negedge clk);
      chk("idle_after_ret", {13'd0, flush_req, redirect, in_trap}, 16'd0);
   endtask

   task automatic pulse(input logic [2:0] f);
      {fault_instr, fault_mem, fault_pc} = f;
      @(negedge clk);
      {fault_instr, fault_mem, fault_pc} = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_flush_req", {15'd0, flush_req}, 16'd0);
      chk("rst_redirect_pc", redirect_pc, 16'h0000);
      chk("rst_epc_cause", {epc[11:0], cause}, 16'h0000);
      chk("rst_trap_df", {14'd0, in_trap, double_fault}, 16'd0);

      // Fault entry and return
      cur_pc = 16'h1234;
      pulse(3'b010);
      repeat (2) @(negedge clk);
      service(4'd1, 16'h0040, 16'h1234);

      // Simultaneous faults drain one per trap
      cur_pc = 16'h2000;
      pulse(3'b111);
      service(4'd0, 16'h0000, 16'h2000);
      service(4'd1, 16'h0040, 16'h2000);
      service(4'd2, 16'h0080, 16'h2000);
      repeat (3) begin
         @(negedge clk);
         chk("no_extra_trap", {15'd0, flush_req}, 16'd0);
      end

      // IRQ masking and arbitration
      cur_pc   = 16'h3000;
      irq      = 4'b0110;
      irq_mask = 4'b0100;
      service(4'd6, 16'h0180, 16'h3000);
      irq_mask = 4'b0110;
      service(4'd5, 16'h0140, 16'h3000);
`ifdef TRAP_IRQ_RR_EN
      service(4'd6, 16'h0180, 16'h3000);
`else
      service(4'd5, 16'h0140, 16'h3000);
`endif
      service(4'd5, 16'h0140, 16'h3000);
      irq      = 4'b0000;
      irq_mask = 4'b0000;
      repeat (2) @(negedge clk);

      // Handshakes in the wrong state are ignored
      drain_ack = 1'b1;
      eret      = 1'b1;
      @(negedge clk);
      drain_ack = 1'b0;
      eret      = 1'b0;
      chk("ignored_hs", {13'd0, flush_req, redirect, in_trap}, 16'd0);

      // Late fault during FLUSH of an IRQ trap
      cur_pc   = 16'h4000;
      irq      = 4'b0001;
      irq_mask = 4'b0001;
      wait_flush();
      irq      = 4'b0000;
      fault_pc = 1'b1;
      eret     = 1'b1;
      cur_pc   = 16'h5000;
      @(negedge clk);
      fault_pc = 1'b0;
      eret     = 1'b0;
      chk("late_still_flush", {15'd0, flush_req}, 16'd1);
      chk("late_cause", {12'd0, cause}, 16'd4);
      chk("late_epc", epc, 16'h4000);
      service(4'd4, 16'h0100, 16'h4000);
      @(negedge clk);
      chk("late_accept_k3", {15'd0, flush_req}, 16'd1);
      service(4'd0, 16'h0000, 16'h5000);

      // Double fault
      cur_pc = 16'h6000;
      pulse(3'b100);
      wait_flush();
      drain_ack = 1'b1;
      @(negedge clk);
      drain_ack = 1'b0;
      @(negedge clk);
      fault_instr = 1'b1;
      @(negedge clk);
      fault_instr = 1'b0;
      chk("df_set", {15'd0, double_fault}, 16'd1);
      drain_ack = 1'b1;
      @(negedge clk);
      drain_ack = 1'b0;
      chk("df_still_handler", {15'd0, in_trap}, 16'd1);
      eret = 1'b1;
      @(negedge clk);
      eret = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("df_no_reentry", {15'd0, flush_req}, 16'd0);
      end
      cur_pc = 16'h7000;
      pulse(3'b001);
      service(4'd0, 16'h0000, 16'h7000);
      chk("df_sticky", {15'd0, double_fault}, 16'd1);

      // Reset mid-operation in VECTOR
      cur_pc = 16'h8000;
      pulse(3'b010);
      wait_flush();
      fault_pc = 1'b1;
      @(negedge clk);
      fault_pc  = 1'b0;
      drain_ack = 1'b1;
      @(negedge clk);
      drain_ack = 1'b0;
      chk("pre_rst_redirect", {15'd0, redirect}, 16'd1);
      #2 rst = 1'b0;
      #1;
      chk("arst_ctrl", {12'd0, flush_req, redirect, in_trap, double_fault}, 16'd0);
      chk("arst_rpc", redirect_pc, 16'h0000);
      chk("arst_epc", epc, 16'h0000);
      chk("arst_cause", {12'd0, cause}, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("pend_cleared", {15'd0, flush_req}, 16'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
